pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Sequences an iCE40 SB_PLL40 primitive: drives its RESETB and BYPASS pins and monitors its LOCK output.
- Releases a system reset to downstream logic only after LOCK has been stable for a qualified interval.
- Retries PLL start-up on lock timeout, falls back to bypass after repeated failures, and re-sequences on lock loss.
- Sits beside the PLL wrapper at top level and runs on the PLL reference clock.

Parameters:
RST_CYCLES, 16, cycles pll_resetb is held low per start attempt (>=1)
LOCK_TIMEOUT, 100000, cycles allowed in WAIT for lock before a retry (1 ms at 100 MHz)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release
MAX_RETRIES, 3, retries after the first attempt before entering FAIL
LOST_W, 8, width of the lock-loss event counter

Ports:
clock_in  in  1  PLL reference clock; the only clock of this block
reset_n  in  1  asynchronous active-low reset
pll_lock  in  1  PLL LOCK output, asynchronous to clock_in
restart  in  1  single-cycle request to re-sequence the PLL from any state
pll_resetb  out  1  to PLL RESETB, active low
pll_bypass  out  1  to PLL BYPASS
sys_rst_n  out  1  active-low system reset for downstream logic
pll_ok  out  1  high only in RUN
fail  out  1  high only in FAIL
state  out  3  current state code
retries  out  $clog2(MAX_RETRIES+1)  retry attempts used in the current sequence
lost_count  out  LOST_W  lock-loss events since reset_n; saturating

Behaviour:
- Reset: asynchronous on reset_n low. Every register and output clears: state=HOLD, pll_resetb=0, pll_bypass=0, sys_rst_n=0, pll_ok=0, fail=0, retries=0, lost_count=0, cycle counter=0, lock synchronizer=0.
- pll_lock passes through a 2-flop synchronizer to produce lock_s. The FSM sees a pll_lock change on the 3rd clock_in edge.
- All outputs are registered and change on the same edge as the state transition that causes them.
- State codes: HOLD=0, WAIT=1, SETTLE=2, RUN=3, FAIL=4.
- HOLD:
  - pll_resetb=0 and sys_rst_n=0.
  - Counter runs 0..RST_CYCLES-1, then the FSM moves to WAIT and clears the counter.
  - pll_resetb is low for exactly RST_CYCLES clocks.
- WAIT:
  - pll_resetb=1.
  - lock_s=1 moves to SETTLE and clears the counter.
  - If the counter reaches LOCK_TIMEOUT-1 with lock_s=0:
    - retries<MAX_RETRIES: increment retries, go to HOLD.
    - otherwise: go to FAIL.
- SETTLE:
  - Requires lock_s=1 for STABLE_CYCLES consecutive cycles.
  - lock_s=0 returns to WAIT with the counter cleared. This is not a retry and retries is unchanged.
  - On completion the FSM goes to RUN. On that edge: sys_rst_n=1, pll_ok=1, retries=0.
- RUN:
  - lock_s=0 moves to HOLD. On that edge: sys_rst_n=0, pll_ok=0.
  - lost_count increments, saturating at all-ones.
- FAIL:
  - pll_bypass=1, pll_resetb=0, sys_rst_n=1 (downstream runs on the bypassed reference clock), fail=1.
  - lock_s is ignored.
  - The FSM stays here until restart or reset_n.
- restart:
  - Highest priority; beats any same-cycle timeout, lock event or completion.
  - From any state, next cycle: state=HOLD, counter=0, retries=0, pll_bypass=0, fail=0, pll_ok=0, sys_rst_n=0.
  - lost_count is preserved.
  - restart held high keeps the FSM in HOLD.
- A lock glitch shorter than 1 clock may be missed. Glitches of 2 or more cycles in RUN always trigger re-sequencing.
- sys_rst_n is asynchronous to the PLL output domain. A reset synchronizer in that domain is required and sits outside this block.

Decomposition:
- Shared package pll_ctrl_pkg holds:
  - state encoding localparams (HOLD..FAIL);
  - the state width constant;
  - a helper for counter width: $clog2 of the max of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES.
- One sub-module: sync_2ff (2-flop synchronizer, async active-low reset to 0), reused for any other asynchronous status input.
- A single shared cycle counter serves HOLD, WAIT and SETTLE.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. reset_n released, pll_lock asserted 5 cycles after pll_resetb rises -> pll_resetb low exactly 4 cycles; state 0->1->2->3; sys_rst_n and pll_ok rise 8 cycles after SETTLE entry; retries=0.
2. pll_lock held 0 -> three WAIT windows of 20 cycles with 4-cycle HOLD pulses between them; retries goes 0,1,2; then state=4, fail=1, pll_bypass=1, pll_resetb=0, sys_rst_n=1.
3. In SETTLE, pll_lock drops for 3 cycles at settle cycle 5 -> returns to WAIT with retries unchanged; after lock returns, full 8-cycle settle, then RUN.
4. In RUN, pll_lock low for 3 cycles -> sys_rst_n=0 on the 3rd edge after the fall; lost_count +1; full re-sequence. Repeating 300 times with LOST_W=8 -> lost_count saturates at 255.
5. restart pulsed in FAIL, and in a separate run restart pulsed in the same cycle as the WAIT timeout -> next state HOLD; fail=0, pll_bypass=0, retries=0; lost_count unchanged.
6. reset_n asserted mid-SETTLE and mid-RUN -> all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared encodings and sizing helpers for the PLL lock supervisor.
// Latency: n/a (constants and elaboration-time functions only).
// Backpressure: n/a.
package pll_ctrl_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_HOLD   = 3'd0;
   localparam logic [STATE_W-1:0] ST_WAIT   = 3'd1;
   localparam logic [STATE_W-1:0] ST_SETTLE = 3'd2;
   localparam logic [STATE_W-1:0] ST_RUN    = 3'd3;
   localparam logic [STATE_W-1:0] ST_FAIL   = 3'd4;

   // One counter serves every timed state, so it is sized for the longest interval.
   // It only ever holds values up to (interval - 1).
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   // Width that holds 0..max_retries inclusive.
   function automatic int ret_width(input int max_retries);
      return (max_retries > 0) ? $clog2(max_retries + 1) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs, clears to 0 on reset.
// Latency: an input change is visible on q after the 2nd clk edge.
// Backpressure: none; level signal, narrow pulses may be lost.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   // Capture the asynchronous input, then re-register it to settle metastability.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences SB_PLL40 RESETB/BYPASS from LOCK and gates the downstream system reset.
// Latency: pll_lock change reaches the FSM on the 3rd clock_in edge; outputs are registered.
// Backpressure: none; restart is accepted in any cycle and overrides everything else.
module pll_lock_supervisor
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 100000,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRIES   = 3,
   parameter int LOST_W        = 8
) (
   input  logic                                clock_in,
   input  logic                                reset_n,
   input  logic                                pll_lock,
   input  logic                                restart,
   output logic                                pll_resetb,
   output logic                                pll_bypass,
   output logic                                sys_rst_n,
   output logic                                pll_ok,
   output logic                                fail,
   output logic [STATE_W-1:0]                  state,
   output logic [ret_width(MAX_RETRIES)-1:0]   retries,
   output logic [LOST_W-1:0]                   lost_count
);

   localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int RET_W = ret_width(MAX_RETRIES);

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RET_W-1:0] RET_MAX     = RET_W'(MAX_RETRIES);

   logic               lock_s;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [STATE_W-1:0] state_nxt;
   logic [RET_W-1:0]   retries_nxt;
   logic               lost_inc;

   sync_2ff #(
      .W (1)
   ) u_lock_sync (
      .clk   (clock_in),
      .rst_n (reset_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // Next-state, shared counter and retry bookkeeping; restart wins over every other event.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      retries_nxt = retries;
      lost_inc    = 1'b0;
      if (restart) begin
         state_nxt   = ST_HOLD;
         cnt_nxt     = '0;
         retries_nxt = '0;
      end else begin
         case (state)
            ST_HOLD: begin
               if (cnt == RST_LAST) begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (lock_s) begin
                  state_nxt = ST_SETTLE;
                  cnt_nxt   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt_nxt = '0;
                  if (retries < RET_MAX) begin
                     retries_nxt = retries + RET_W'(1);
                     state_nxt   = ST_HOLD;
                  end else begin
                     state_nxt = ST_FAIL;
                  end
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_SETTLE: begin
               // A dropout restarts qualification but is not counted as a retry.
               if (!lock_s) begin
                  state_nxt = ST_WAIT;
                  cnt_nxt   = '0;
               end else if (cnt == STABLE_LAST) begin
                  state_nxt   = ST_RUN;
                  cnt_nxt     = '0;
                  retries_nxt = '0;
               end else begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_nxt = ST_HOLD;
                  cnt_nxt   = '0;
                  lost_inc  = 1'b1;
               end
            end
            ST_FAIL: begin
               // Parked on the bypassed reference clock until restart or reset_n.
            end
            default: begin
               state_nxt = ST_HOLD;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // State, counter and outputs; outputs decode the next state so they move on the transition edge.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_HOLD;
         cnt        <= '0;
         retries    <= '0;
         lost_count <= '0;
         pll_resetb <= 1'b0;
         pll_bypass <= 1'b0;
         sys_rst_n  <= 1'b0;
         pll_ok     <= 1'b0;
         fail       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         retries    <= retries_nxt;
         pll_resetb <= (state_nxt == ST_WAIT) || (state_nxt == ST_SETTLE) ||
                       (state_nxt == ST_RUN);
         pll_bypass <= (state_nxt == ST_FAIL);
         sys_rst_n  <= (state_nxt == ST_RUN) || (state_nxt == ST_FAIL);
         pll_ok     <= (state_nxt == ST_RUN);
         fail       <= (state_nxt == ST_FAIL);
         if (lost_inc && (lost_count != {LOST_W{1'b1}})) begin
            lost_count <= lost_count + LOST_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: vector table plus multi-cycle corner sequences.
// Inputs are driven and outputs sampled 1 ns after each rising clock_in edge.
// Small parameters keep every interval hand-countable.
module tb_pll_lock_supervisor;

   localparam int RST_CYCLES    = 4;
   localparam int LOCK_TIMEOUT  = 20;
   localparam int STABLE_CYCLES = 8;
   localparam int MAX_RETRIES   = 2;
   localparam int LOST_W        = 8;

   logic              clock_in;
   logic              reset_n;
   logic              pll_lock;
   logic              restart;
   logic              pll_resetb;
   logic              pll_bypass;
   logic              sys_rst_n;
   logic              pll_ok;
   logic              fail;
   logic [2:0]        state;
   logic [1:0]        retries;
   logic [LOST_W-1:0] lost_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       lock;
      logic       rst;
      int         n;
      logic [2:0] st;
      logic       rb;
      logic       byp;
      logic       sr;
      logic       ok;
      logic       fl;
      int         rt;
      int         lc;
   } vec_t;

   vec_t vecs [19];

   pll_lock_supervisor #(
      .RST_CYCLES    (RST_CYCLES),
      .LOCK_TIMEOUT  (LOCK_TIMEOUT),
      .STABLE_CYCLES (STABLE_CYCLES),
      .MAX_RETRIES   (MAX_RETRIES),
      .LOST_W        (LOST_W)
   ) dut (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .pll_lock   (pll_lock),
      .restart    (restart),
      .pll_resetb (pll_resetb),
      .pll_bypass (pll_bypass),
      .sys_rst_n  (sys_rst_n),
      .pll_ok     (pll_ok),
      .fail       (fail),
      .state      (state),
      .retries    (retries),
      .lost_count (lost_count)
   );

   initial begin
      clock_in = 1'b0;
      forever #5 clock_in = ~clock_in;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock_in);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string name, input logic [2:0] st, input logic rb,
                           input logic byp, input logic sr, input logic ok, input logic fl,
                           input int rt, input int lc);
      chk({name, ".state"},      32'(state),      32'(st));
      chk({name, ".pll_resetb"}, 32'(pll_resetb), 32'(rb));
      chk({name, ".pll_bypass"}, 32'(pll_bypass), 32'(byp));
      chk({name, ".sys_rst_n"},  32'(sys_rst_n),  32'(sr));
      chk({name, ".pll_ok"},     32'(pll_ok),     32'(ok));
      chk({name, ".fail"},       32'(fail),       32'(fl));
      chk({name, ".retries"},    32'(retries),    rt);
      chk({name, ".lost_count"}, 32'(lost_count), lc);
   endtask

   // Steps until state matches or the budget expires; the final comparison reports a timeout.
   task automatic wait_state(input logic [2:0] tgt, input int budget, input string name);
      int n;
      n = 0;
      while ((state !== tgt) && (n < budget)) begin
         step(1);
         n++;
      end
      chk(name, 32'(state), 32'(tgt));
   endtask

   initial begin
      // lock, restart, cycles, state, resetb, bypass, sys_rst_n, ok, fail, retries, lost
      vecs[0]  = '{1'b0, 1'b0, 3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[1]  = '{1'b0, 1'b0, 1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[2]  = '{1'b0, 1'b0, 5, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[3]  = '{1'b1, 1'b0, 2, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[4]  = '{1'b1, 1'b0, 1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[5]  = '{1'b1, 1'b0, 7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      vecs[6]  = '{1'b1, 1'b0, 1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
      vecs[7]  = '{1'b1, 1'b0, 5, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
      vecs[8]  = '{1'b0, 1'b0, 2, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
      vecs[9]  = '{1'b0, 1'b0, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[10] = '{1'b1, 1'b0, 3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[11] = '{1'b1, 1'b0, 1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[12] = '{1'b1, 1'b0, 1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[13] = '{1'b1, 1'b0, 7, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[14] = '{1'b1, 1'b0, 1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
      vecs[15] = '{1'b1, 1'b1, 1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[16] = '{1'b1, 1'b0, 4, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[17] = '{1'b1, 1'b0, 1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
      vecs[18] = '{1'b1, 1'b0, 8, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};

      reset_n  = 1'b0;
      pll_lock = 1'b0;
      restart  = 1'b0;
      step(2);
      chk_outs("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      reset_n = 1'b1;

      // Start-up, lock-in, one lock loss and a restart from RUN.
      for (int i = 0; i < 19; i++) begin
         pll_lock = vecs[i].lock;
         restart  = vecs[i].rst;
         step(vecs[i].n);
         chk_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].rb, vecs[i].byp, vecs[i].sr,
                  vecs[i].ok, vecs[i].fl, vecs[i].rt, vecs[i].lc);
      end
      restart = 1'b0;

      // Repeated 3-cycle lock losses in RUN until lost_count saturates.
      for (int i = 2; i <= 300; i++) begin
         pll_lock = 1'b0;
         step(3);
         pll_lock = 1'b1;
         wait_state(3'd3, 60, "resync_run");
         if (i == 254) chk("lost_254", 32'(lost_count), 254);
         if (i == 255) chk("lost_255", 32'(lost_count), 255);
      end
      chk("lost_sat", 32'(lost_count), 255);

      // Permanent lock loss from RUN exhausts the retries and parks in FAIL.
      pll_lock = 1'b0;
      wait_state(3'd4, 200, "reach_fail");
      chk_outs("in_fail", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 255);

      // Restart pulse in FAIL, then restart held high keeps HOLD.
      restart = 1'b1;
      step(1);
      chk_outs("restart_fail", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 255);
      step(9);
      chk_outs("restart_held", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 255);
      restart = 1'b0;

      // Restart coincident with the final WAIT timeout must win over FAIL.
      step(71);
      chk_outs("pre_last_timeout", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 255);
      restart = 1'b1;
      step(1);
      chk_outs("restart_timeout", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 255);
      restart = 1'b0;

      // Asynchronous reset in SETTLE, checked before any clock edge.
      pll_lock = 1'b1;
      wait_state(3'd2, 50, "reach_settle");
      step(2);
      #2 reset_n = 1'b0;
      #1;
      chk_outs("arst_settle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1);
      reset_n = 1'b1;

      // Asynchronous reset in RUN.
      wait_state(3'd3, 100, "reach_run");
      step(2);
      #2 reset_n = 1'b0;
      #1;
      chk_outs("arst_run", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

      // No lock at all: three 20-cycle WAIT windows separated by 4-cycle HOLD pulses, then FAIL.
      pll_lock = 1'b0;
      step(1);
      reset_n = 1'b1;
      step(23);
      chk_outs("nolock_w0_end", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
      step(1);
      chk_outs("nolock_retry1", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
      step(3);
      chk("nolock_hold1", 32'(state), 0);
      step(1);
      chk_outs("nolock_w1", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
      step(19);
      chk("nolock_w1_end", 32'(state), 1);
      step(1);
      chk_outs("nolock_retry2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0);
      step(4);
      chk("nolock_w2", 32'(state), 1);
      step(19);
      chk("nolock_w2_end", 32'(state), 1);
      step(1);
      chk_outs("nolock_fail", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 0);
      pll_lock = 1'b1;
      step(10);
      chk_outs("fail_ignores_lock", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 0);

      // Lock dropout during SETTLE after one retry: back to WAIT, retries kept, full re-settle.
      reset_n = 1'b0;
      pll_lock = 1'b0;
      step(1);
      reset_n = 1'b1;
      step(24);
      chk("settle_retry1", 32'(retries), 1);
      step(4);
      chk("settle_wait", 32'(state), 1);
      pll_lock = 1'b1;
      step(2);
      chk("settle_sync_delay", 32'(state), 1);
      step(1);
      chk("settle_enter", 32'(state), 2);
      step(4);
      pll_lock = 1'b0;
      step(2);
      chk("settle_drop_pending", 32'(state), 2);
      step(1);
      chk_outs("settle_dropout", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
      pll_lock = 1'b1;
      step(2);
      chk("settle_rewait", 32'(state), 1);
      step(1);
      chk("settle_reenter", 32'(state), 2);
      step(7);
      chk_outs("settle_almost", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
      step(1);
      chk_outs("settle_run", 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
